// File: rtl/fpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fpu_pkg                                                    |
// | Purpose : Shared types, opcodes and constants for the binary32 FPU   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_EXEC   = 3'd2,
    ST_NORM   = 3'd3,
    ST_PACK   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;      // hidden bit included; zero for zero/subnormal
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } operand_t;

  // Split a binary32 word into fields; subnormals collapse to signed zero.
  // flip inverts the sign so subtraction can reuse the addition path.
  function automatic operand_t unpack(input logic [31:0] v, input logic flip);
    operand_t o;
    o.sign    = v[31] ^ flip;
    o.exp     = v[FRAC_W+EXP_W-1:FRAC_W];
    o.is_zero = (o.exp == 8'd0);
    o.is_inf  = (o.exp == 8'hFF) && (v[FRAC_W-1:0] == '0);
    o.is_nan  = (o.exp == 8'hFF) && (v[FRAC_W-1:0] != '0);
    o.sig     = o.is_zero ? 24'd0 : {1'b1, v[FRAC_W-1:0]};
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fpu_if                                                     |
// | Purpose : start/done request bundle between requester and FPU        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface fpu_if;
  logic        start;
  logic [3:0]  opcode;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [31:0] result_out;
  logic        done;

  modport master (
    output start, opcode, A_in, B_in,
    input  result_out, done
  );

  modport slave (
    input  start, opcode, A_in, B_in,
    output result_out, done
  );
endinterface
`default_nettype wire

// File: rtl/fpu_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fpu_lzc                                                    |
// | Purpose : 28-bit combinational leading-zero counter (28 when zero)   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module fpu_lzc (
  input  wire  [27:0] i_val,
  output logic [4:0]  o_cnt
);

  // Scan upward so the highest set bit makes the final assignment.
  always_comb begin
    o_cnt = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (i_val[i]) o_cnt = 5'(27 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fpu_core                                                   |
// | Purpose : binary32 ADD/SUB/MUL unit, fixed 4-edge latency FSM        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module fpu_core
  import fpu_pkg::*;
(
  input wire   clk,
  input wire   rst,     // asynchronous, active-low
  fpu_if.slave bus
);

  state_t r_state, w_next;
  logic   w_accept;

  logic [3:0]  r_op;
  logic [31:0] r_a, r_b;
  operand_t    r_ua, r_ub;

  // EXEC-stage results; held stable through NORM and PACK
  logic               r_sign, r_special, r_cancel;
  logic [31:0]        r_spec_val;
  logic signed [10:0] r_exp;
  logic [27:0]        r_mag;   // [27] carry, [26] hidden, [2:0] guard/round/sticky

  // NORM-stage results
  logic [27:0]        r_norm;  // leading one at bit 27
  logic signed [10:0] r_nexp;

  logic [31:0] r_result;
  logic        r_done;

  assign w_accept       = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign bus.result_out = r_result;
  assign bus.done       = r_done;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state: linear pipeline walk, start only honoured in IDLE/DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_UNPACK;
      ST_UNPACK: w_next = ST_EXEC;
      ST_EXEC:   w_next = ST_NORM;
      ST_NORM:   w_next = ST_PACK;
      ST_PACK:   w_next = ST_DONE;
      ST_DONE:   if (w_accept) w_next = ST_UNPACK;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Latch request on accept; later bus changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op <= 4'd0;
      r_a  <= 32'd0;
      r_b  <= 32'd0;
    end else if (w_accept) begin
      r_op <= bus.opcode;
      r_a  <= bus.A_in;
      r_b  <= bus.B_in;
    end
  end

  // UNPACK: field split, B sign flipped for subtraction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ua <= '0;
      r_ub <= '0;
    end else if (r_state == ST_UNPACK) begin
      r_ua <= unpack(r_a, 1'b0);
      r_ub <= unpack(r_b, r_op == OP_SUB);
    end
  end

  // ---------------- EXEC datapath ----------------
  operand_t           w_x, w_y;
  logic [7:0]         w_diff;
  logic [4:0]         w_shamt;
  logic [50:0]        w_tmp;
  logic [26:0]        w_aligned;
  logic [27:0]        w_xext, w_mag;
  logic [47:0]        w_prod;
  logic               w_eff_sub, w_sign, w_special, w_cancel;
  logic [31:0]        w_spec_val;
  logic signed [10:0] w_exp;

  // Align/add magnitudes or multiply significands; resolve special operands
  always_comb begin
    w_x = r_ua;
    w_y = r_ub;
    if ({r_ub.exp, r_ub.sig} > {r_ua.exp, r_ua.sig}) begin
      w_x = r_ub;
      w_y = r_ua;
    end
    w_diff    = w_x.exp - w_y.exp;
    w_shamt   = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];
    // bits pushed below the sticky position are ORed back into it
    w_tmp     = {w_y.sig, 27'd0} >> w_shamt;
    w_aligned = {w_tmp[50:25], w_tmp[24] | (|w_tmp[23:0])};
    w_xext    = {1'b0, w_x.sig, 3'b000};
    w_eff_sub = r_ua.sign ^ r_ub.sign;
    w_prod    = 48'(r_ua.sig) * 48'(r_ub.sig);

    w_sign     = 1'b0;
    w_exp      = '0;
    w_mag      = '0;
    w_cancel   = 1'b0;
    w_special  = 1'b0;
    w_spec_val = 32'd0;

    if (r_op == OP_MUL) begin
      w_sign = r_ua.sign ^ r_ub.sign;
      w_exp  = 11'(r_ua.exp) + 11'(r_ub.exp) - 11'(BIAS);
      // product bit 46 lands on the hidden position, bit 47 on the carry
      w_mag  = {w_prod[47:21], |w_prod[20:0]};
      if (r_ua.is_nan || r_ub.is_nan) begin
        w_special = 1'b1; w_spec_val = QNAN;
      end else if ((r_ua.is_zero && r_ub.is_inf) || (r_ua.is_inf && r_ub.is_zero)) begin
        w_special = 1'b1; w_spec_val = QNAN;
      end else if (r_ua.is_inf || r_ub.is_inf) begin
        w_special = 1'b1; w_spec_val = {w_sign, POS_INF[30:0]};
      end else if (r_ua.is_zero || r_ub.is_zero) begin
        w_special = 1'b1; w_spec_val = {w_sign, 31'd0};
      end
    end else if (r_op == OP_ADD || r_op == OP_SUB) begin
      w_sign   = w_x.sign;
      w_exp    = 11'(w_x.exp);
      w_mag    = w_eff_sub ? (w_xext - {1'b0, w_aligned}) : (w_xext + {1'b0, w_aligned});
      w_cancel = (w_mag == 28'd0);
      if (r_ua.is_nan || r_ub.is_nan) begin
        w_special = 1'b1; w_spec_val = QNAN;
      end else if (r_ua.is_inf && r_ub.is_inf && w_eff_sub) begin
        w_special = 1'b1; w_spec_val = QNAN;
      end else if (r_ua.is_inf) begin
        w_special = 1'b1; w_spec_val = {r_ua.sign, POS_INF[30:0]};
      end else if (r_ub.is_inf) begin
        w_special = 1'b1; w_spec_val = {r_ub.sign, POS_INF[30:0]};
      end else if (r_ua.is_zero && r_ub.is_zero) begin
        w_special = 1'b1; w_spec_val = {r_ua.sign & r_ub.sign, 31'd0};
      end
    end else begin
      w_special  = 1'b1;
      w_spec_val = 32'd0;
    end
  end

  // EXEC register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_mag      <= '0;
      r_cancel   <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= 32'd0;
    end else if (r_state == ST_EXEC) begin
      r_sign     <= w_sign;
      r_exp      <= w_exp;
      r_mag      <= w_mag;
      r_cancel   <= w_cancel;
      r_special  <= w_special;
      r_spec_val <= w_spec_val;
    end
  end

  // ---------------- NORM datapath ----------------
  logic [4:0] w_lz;

  fpu_lzc u_lzc (
    .i_val (r_mag),
    .o_cnt (w_lz)
  );

  // NORM register stage: shift leading one to bit 27, rebalance exponent
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_norm <= '0;
      r_nexp <= '0;
    end else if (r_state == ST_NORM) begin
      r_norm <= r_mag << w_lz;
      r_nexp <= r_exp + 11'sd1 - $signed({6'd0, w_lz});
    end
  end

  // ---------------- PACK datapath ----------------
  logic               w_up;
  logic [24:0]        w_sum25;
  logic [22:0]        w_frac;
  logic signed [10:0] w_fexp;
  logic [31:0]        w_pack;

  // Round to nearest-even, renormalise on carry-out, then range-check
  always_comb begin
    w_up    = r_norm[3] & (r_norm[2] | (|r_norm[1:0]) | r_norm[4]);
    w_sum25 = {1'b0, r_norm[27:4]} + {24'd0, w_up};
    if (w_sum25[24]) begin
      w_frac = w_sum25[23:1];
      w_fexp = r_nexp + 11'sd1;
    end else begin
      w_frac = w_sum25[22:0];
      w_fexp = r_nexp;
    end
    if (r_special)               w_pack = r_spec_val;
    else if (r_cancel)           w_pack = 32'd0;
    else if (w_fexp >= 11'sd255) w_pack = r_sign ? NEG_INF : POS_INF;
    else if (w_fexp <= 11'sd0)   w_pack = {r_sign, 31'd0};
    else                         w_pack = {r_sign, w_fexp[7:0], w_frac};
  end

  // Result and done: result updates on PACK->DONE only, done drops on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= 32'd0;
      r_done   <= 1'b0;
    end else if (r_state == ST_PACK) begin
      r_result <= w_pack;
      r_done   <= 1'b1;
    end else if (w_accept) begin
      r_done   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fpu_core                                                |
// | Purpose : scoreboard bench for fpu_core with directed vectors        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_fpu_core;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_if bus ();

  fpu_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$];
  int          acc_q[$];

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV] = '{
    '{OP_SUB,  32'h40A00000, 32'h40400000, 32'h40000000},  // 5 - 3 = 2
    '{OP_SUB,  32'h3F800000, 32'h3F800000, 32'h00000000},  // exact cancel -> +0
    '{OP_ADD,  32'h3F800000, 32'h33800000, 32'h3F800000},  // tie, even stays
    '{OP_ADD,  32'h3F800001, 32'h33800000, 32'h3F800002},  // tie, odd rounds up
    '{OP_ADD,  32'h3F7FFFFF, 32'h33000000, 32'h3F800000},  // rounding carry-out
    '{OP_MUL,  32'h40200000, 32'hC0800000, 32'hC1200000},  // 2.5 * -4 = -10
    '{OP_MUL,  32'h7F7FFFFF, 32'h40000000, 32'h7F800000},  // overflow
    '{OP_ADD,  32'h7FC00000, 32'h3F800000, 32'h7FC00000},  // NaN in
    '{OP_SUB,  32'h7F800000, 32'h7F800000, 32'h7FC00000},  // inf - inf
    '{OP_MUL,  32'h00000000, 32'h7F800000, 32'h7FC00000},  // 0 * inf
    '{OP_ADD,  32'h80000000, 32'h80000000, 32'h80000000},  // -0 + -0
    '{OP_MUL,  32'h00800000, 32'h00800000, 32'h00000000},  // underflow flush
    '{4'b0011, 32'h3F800000, 32'h3F800000, 32'h00000000},  // reserved opcode
    '{OP_ADD,  32'hFF800000, 32'h3F800000, 32'hFF800000},  // -inf + 1
    '{OP_MUL,  32'h80000000, 32'h3F800000, 32'h80000000}   // -0 * 1
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each rising done pops one expected result and its accept cycle
  logic        prev_done = 1'b0;
  logic [31:0] m_exp;
  int          m_acc;
  always @(negedge clk) begin
    if (rst && bus.done && !prev_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got result %08h, required no output", bus.result_out);
      end else begin
        m_exp = exp_q.pop_front();
        m_acc = acc_q.pop_front();
        check("result", bus.result_out, m_exp);
        check("latency", 32'(cyc - m_acc), 32'd4);
      end
    end
    prev_done <= bus.done;
  end

  // Drive one request across an edge, then scramble the bus
  task automatic do_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.A_in   = a;
    bus.B_in   = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.opcode = 4'($urandom_range(0, 15));
    bus.A_in   = $urandom();
    bus.B_in   = $urandom();
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r);
    do_start(op, a, b);
    acc_q.push_back(cyc);
    exp_q.push_back(r);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!bus.done && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, required done=1", k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  logic [31:0] last;

  initial begin
    bus.start  = 1'b0;
    bus.opcode = 4'd0;
    bus.A_in   = 32'd0;
    bus.B_in   = 32'd0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result_out, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // first op plus hold behaviour
    issue(OP_ADD, 32'h3FC00000, 32'h40100000, 32'h40700000);
    wait_done();
    repeat (3) @(negedge clk);
    check("hold_result", bus.result_out, 32'h40700000);
    check("hold_done", 32'(bus.done), 32'd1);
    last = 32'h40700000;

    // table, each one accepted from DONE
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r);
      check("accept_drops_done", 32'(bus.done), 32'd0);
      check("busy_keeps_result", bus.result_out, last);
      wait_done();
      last = vecs[i].r;
    end

    // start during EXEC must be ignored
    issue(OP_MUL, 32'h40200000, 32'hC0800000, 32'hC1200000);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = OP_ADD;
    bus.A_in   = 32'h3F800000;
    bus.B_in   = 32'h3F800000;
    @(negedge clk);
    bus.start  = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    check("ignored_start_result", bus.result_out, 32'hC1200000);
    check("ignored_start_done", 32'(bus.done), 32'd1);

    // reset during NORM aborts the operation
    do_start(OP_ADD, 32'h3FC00000, 32'h40100000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_done", 32'(bus.done), 32'd0);
    check("midreset_result", bus.result_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_done", 32'(bus.done), 32'd0);
    check("post_reset_result", bus.result_out, 32'd0);

    // recovery after reset
    issue(OP_SUB, 32'h40A00000, 32'h40400000, 32'h40000000);
    wait_done();
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
